// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// urv_typedef / dmem_responder
//
// urv_typedef holds the LSU data-bus request type shared with the core.
//
// dmem_responder is the data-memory responder for the LSU data bus.
//   - Accepts one request per valid/ready handshake.
//   - Inserts WAIT_CYCLES wait states before asserting ready.
//   - Writes apply per byte under req_mask. Reads always return the full word.
//   - The response (rdata/err) is registered and appears one cycle after the
//     handshake, lined up with the LSU->WB stage.
//   - It is used both as the simulation data memory and as the FPGA
//     tightly-coupled data RAM.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, >= 4)
//   BASE_ADDR    byte address of word 0 (aligned to DEPTH*4)
//   WAIT_CYCLES  wait states before ready (0..15)
//
// Ports
//   clk              in   clock, rising edge
//   rst              in   asynchronous active-high reset
//   dmem_req_valid   in   request present, held until handshake
//   dmem_req_ready   out  request accepted this cycle (combinational)
//   dmem_req         in   mem_req_t request
//   dmem_resp_valid  out  one-cycle pulse after each handshake
//   dmem_resp_rdata  out  read word; 0 for writes and errors
//   dmem_resp_err    out  out-of-range access flag
// -----------------------------------------------------------------------------
package urv_typedef;

  typedef enum logic [0:0] {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_type_t;

  typedef struct packed {
    mem_type_t   req_type;
    logic [31:0] req_addr;
    logic [3:0]  req_mask;
    logic [31:0] req_data;
  } mem_req_t;

endpackage

module dmem_responder
  import urv_typedef::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_req_valid,
  output logic        dmem_req_ready,
  input  mem_req_t    dmem_req,
  output logic        dmem_resp_valid,
  output logic [31:0] dmem_resp_rdata,
  output logic        dmem_resp_err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [31:0]   mem [DEPTH];

  logic [0:0]    state_reg;
  logic [0:0]    state_next;
  logic [3:0]    wcnt_reg;
  logic [3:0]    wcnt_next;

  logic          resp_valid_reg;
  logic          resp_err_reg;
  logic          rd_ok_reg;     // last response was an in-range read
  logic [31:0]   mem_q_reg;     // registered RAM read port

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          handshake;
  logic          is_write;
  logic          unused_off_lsb;

  // BASE_ADDR is aligned to the array size, so the offset is in range exactly
  // when every bit above the word index is zero. Addresses below BASE_ADDR
  // wrap to large offsets and are therefore rejected too.
  assign off      = dmem_req.req_addr - BASE_ADDR;
  assign in_range = (off[31:AW+2] == '0);
  assign idx      = off[AW+1:2];
  assign is_write = (dmem_req.req_type == MEM_WRITE);

  // Sub-word byte offset is resolved in WB, not here.
  assign unused_off_lsb = &{1'b0, off[1:0]};

  // ---------------------------------------------------------------------------
  // Ready / FSM next-state
  // ---------------------------------------------------------------------------
  // Ready is gated by rst so that all outputs drop to 0 as soon as reset is
  // asserted, and it never rises without valid.
  always_comb begin
    dmem_req_ready = 1'b0;
    if (!rst && dmem_req_valid) begin
      case (state_reg)
        ST_IDLE: dmem_req_ready = (WAIT_CYCLES == 0);
        ST_WAIT: dmem_req_ready = (wcnt_reg == WAIT_LAST);
        default: dmem_req_ready = 1'b0;
      endcase
    end
  end

  assign handshake = dmem_req_valid && dmem_req_ready;

  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (dmem_req_valid && (WAIT_CYCLES != 0)) begin
          state_next = ST_WAIT;
          wcnt_next  = 4'd1;
        end
      end
      ST_WAIT: begin
        // A dropped valid is an LSU flush: the pending request is discarded.
        // After a handshake the counter restarts, so every request pays the
        // full wait.
        if (!dmem_req_valid || dmem_req_ready) begin
          state_next = ST_IDLE;
          wcnt_next  = 4'd0;
        end else begin
          wcnt_next  = wcnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        wcnt_next  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      wcnt_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM: byte-masked write port and registered read port.
  // The array itself has no reset. The read port is loaded only for in-range
  // read handshakes and then held, so the plain RAM output register can be
  // used. Write and read of the same request never collide, because a request
  // is either a read or a write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (handshake && in_range) begin
      if (is_write) begin
        for (int b = 0; b < 4; b++) begin
          if (dmem_req.req_mask[b]) begin
            mem[idx][8*b +: 8] <= dmem_req.req_data[8*b +: 8];
          end
        end
      end else begin
        mem_q_reg <= mem[idx];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      rd_ok_reg      <= 1'b0;
    end else begin
      resp_valid_reg <= handshake;
      if (handshake) begin
        resp_err_reg <= !in_range;
        rd_ok_reg    <= in_range && !is_write;
      end
    end
  end

  // Writes and errors report zero data. This also covers the uninitialised
  // RAM output register after reset.
  assign dmem_resp_valid = resp_valid_reg;
  assign dmem_resp_err   = resp_err_reg;
  assign dmem_resp_rdata = rd_ok_reg ? mem_q_reg : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed testbench with hand-computed expected values. It uses two DUT
// instances that share the clock and reset:
//   u_dut0 : WAIT_CYCLES=0, BASE_ADDR=0x1000_0000, DEPTH=1024
//   u_dut1 : WAIT_CYCLES=3, BASE_ADDR=0x0000_0000, DEPTH=1024
// Inputs are driven and outputs are sampled just after the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
  import urv_typedef::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid [2];
  mem_req_t    req   [2];
  logic [1:0]  ready;
  logic [1:0]  rvalid;
  logic [1:0]  err;
  logic [31:0] rdata [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .BASE_ADDR(32'h1000_0000), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .dmem_req_valid(valid[0]), .dmem_req_ready(ready[0]), .dmem_req(req[0]),
    .dmem_resp_valid(rvalid[0]), .dmem_resp_rdata(rdata[0]), .dmem_resp_err(err[0])
  );

  dmem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .dmem_req_valid(valid[1]), .dmem_req_ready(ready[1]), .dmem_req(req[1]),
    .dmem_resp_valid(rvalid[1]), .dmem_resp_rdata(rdata[1]), .dmem_resp_err(err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic set_req(input int d, input logic wr, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data);
    req[d].req_type = wr ? MEM_WRITE : MEM_READ;
    req[d].req_addr = addr;
    req[d].req_mask = mask;
    req[d].req_data = data;
  endtask

  // One complete transfer. It returns the response data and error flag, and
  // the number of cycles between raising valid and the handshake.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [3:0] mask, input logic [31:0] data,
                      output logic [31:0] rd, output logic e, output int n);
    @(negedge clk);
    valid[d] = 1'b1;
    set_req(d, wr, addr, mask, data);
    #1;
    n = 0;
    while (!ready[d] && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 40) begin
      check("hs_timeout", 32'(n), 32'd0);
      valid[d] = 1'b0;
      rd = 'x;
      e  = 1'bx;
    end else begin
      @(negedge clk);
      #1;
      check("resp_valid", 32'(rvalid[d]), 32'd1);
      rd = rdata[d];
      e  = err[d];
      valid[d] = 1'b0;
      @(negedge clk);
      #1;
      check("resp_pulse_end", 32'(rvalid[d]), 32'd0);
    end
  endtask

  logic [31:0] rd;
  logic        e;
  int          n;

  initial begin
    valid[0] = 1'b1;            // valid during reset must not produce ready
    valid[1] = 1'b0;
    set_req(0, 1'b0, 32'h1000_0000, 4'h0, 32'h0);
    set_req(1, 1'b0, 32'h0, 4'h0, 32'h0);

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready0",  32'(ready[0]),  32'd0);
    check("rst_rvalid0", 32'(rvalid[0]), 32'd0);
    check("rst_rdata0",  rdata[0],       32'd0);
    check("rst_err0",    32'(err[0]),    32'd0);
    check("rst_rvalid1", 32'(rvalid[1]), 32'd0);
    valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // ---------------- zero-wait write then read ----------------
    @(negedge clk);
    valid[0] = 1'b1;
    set_req(0, 1'b1, 32'h1000_0010, 4'hF, 32'hDEAD_BEEF);
    #1;
    check("zw_ready_wr", 32'(ready[0]), 32'd1);
    @(negedge clk);
    set_req(0, 1'b0, 32'h1000_0010, 4'h0, 32'h0);
    #1;
    check("zw_ready_rd",   32'(ready[0]),  32'd1);
    check("zw_wr_rvalid",  32'(rvalid[0]), 32'd1);
    check("zw_wr_rdata",   rdata[0],       32'd0);
    check("zw_wr_err",     32'(err[0]),    32'd0);
    @(negedge clk);
    valid[0] = 1'b0;
    #1;
    check("zw_rd_rvalid", 32'(rvalid[0]), 32'd1);
    check("zw_rd_rdata",  rdata[0],       32'hDEAD_BEEF);
    check("zw_rd_err",    32'(err[0]),    32'd0);

    // ---------------- byte masks ----------------
    xfer(0, 1'b1, 32'h1000_0010, 4'hF, 32'h1122_3344, rd, e, n);
    check("bm_pre_lat", 32'(n), 32'd0);
    xfer(0, 1'b1, 32'h1000_0010, 4'b0100, 32'hAABB_CCDD, rd, e, n);
    xfer(0, 1'b0, 32'h1000_0010, 4'h0, 32'h0, rd, e, n);
    check("bm_byte2", rd, 32'h11BB_3344);
    xfer(0, 1'b1, 32'h1000_0010, 4'b0000, 32'hFFFF_FFFF, rd, e, n);
    check("bm_mask0_err", 32'(e), 32'd0);
    xfer(0, 1'b0, 32'h1000_0010, 4'h0, 32'h0, rd, e, n);
    check("bm_mask0_keep", rd, 32'h11BB_3344);
    xfer(0, 1'b0, 32'h1000_0013, 4'h0, 32'h0, rd, e, n);
    check("bm_lsb_ignored", rd, 32'h11BB_3344);

    // ---------------- range boundaries on dut0 ----------------
    xfer(0, 1'b1, 32'h1000_0FFC, 4'hF, 32'hCAFE_F00D, rd, e, n);
    check("last_wr_err", 32'(e), 32'd0);
    xfer(0, 1'b0, 32'h1000_0FFC, 4'h0, 32'h0, rd, e, n);
    check("last_rd_data", rd, 32'hCAFE_F00D);
    xfer(0, 1'b0, 32'h1000_1000, 4'h0, 32'h0, rd, e, n);
    check("above_err",   32'(e), 32'd1);
    check("above_rdata", rd,     32'd0);
    xfer(0, 1'b0, 32'h0FFF_FFFC, 4'h0, 32'h0, rd, e, n);
    check("below_err",   32'(e), 32'd1);

    // ---------------- wait states, back-to-back ----------------
    @(negedge clk);
    valid[1] = 1'b1;
    set_req(1, 1'b1, 32'h0000_0008, 4'hF, 32'h5555_AAAA);
    #1;
    check("ws_c0_ready", 32'(ready[1]), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("ws_c%0d_ready", c), 32'(ready[1]), (c == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    #1;
    check("ws_c4_rvalid", 32'(rvalid[1]), 32'd1);
    check("ws_c4_ready",  32'(ready[1]),  32'd0);
    check("ws_c4_rdata",  rdata[1],       32'd0);
    set_req(1, 1'b0, 32'h0000_0008, 4'h0, 32'h0);
    for (int c = 5; c <= 7; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("ws_c%0d_ready", c), 32'(ready[1]), (c == 7) ? 32'd1 : 32'd0);
      if (c == 5) check("ws_c5_rvalid", 32'(rvalid[1]), 32'd0);
    end
    @(negedge clk);
    #1;
    check("ws_c8_rvalid", 32'(rvalid[1]), 32'd1);
    check("ws_c8_rdata",  rdata[1],       32'h5555_AAAA);
    valid[1] = 1'b0;

    // ---------------- abort ----------------
    xfer(1, 1'b1, 32'h0000_0000, 4'hF, 32'h0BAD_F00D, rd, e, n);
    check("ab_pre_lat", 32'(n), 32'd3);
    @(negedge clk);
    valid[1] = 1'b1;
    set_req(1, 1'b1, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk);
    valid[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check("ab_no_resp", 32'(rvalid[1]), 32'd0);
    end
    xfer(1, 1'b0, 32'h0000_0000, 4'h0, 32'h0, rd, e, n);
    check("ab_lat",   32'(n), 32'd3);
    check("ab_keep",  rd,     32'h0BAD_F00D);

    // ---------------- out of range, no aliasing ----------------
    xfer(1, 1'b1, 32'h0000_1000, 4'hF, 32'h1234_5678, rd, e, n);
    check("oor_wr_err",   32'(e), 32'd1);
    check("oor_wr_rdata", rd,     32'd0);
    xfer(1, 1'b0, 32'h0000_1000, 4'h0, 32'h0, rd, e, n);
    check("oor_rd_err",   32'(e), 32'd1);
    check("oor_rd_rdata", rd,     32'd0);
    xfer(1, 1'b0, 32'h0000_0000, 4'h0, 32'h0, rd, e, n);
    check("oor_word0",    rd,     32'h0BAD_F00D);
    check("oor_word0_err", 32'(e), 32'd0);

    // ---------------- async reset mid-WAIT ----------------
    // The previous read leaves rdata non-zero, so clearing it shows the reset.
    @(negedge clk);
    valid[1] = 1'b1;
    set_req(1, 1'b1, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk);
    #3;
    rst = 1'b1;
    valid[1] = 1'b0;
    #1;
    check("ar_ready",  32'(ready[1]),  32'd0);
    check("ar_rvalid", 32'(rvalid[1]), 32'd0);
    check("ar_rdata",  rdata[1],       32'd0);
    check("ar_err",    32'(err[1]),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    xfer(1, 1'b0, 32'h0000_0000, 4'h0, 32'h0, rd, e, n);
    check("ar_post_lat",  32'(n), 32'd3);
    check("ar_post_data", rd,     32'h0BAD_F00D);
    check("ar_post_err",  32'(e), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
